// File: rtl/psum_requant_pack.sv
// -----------------------------------------------------------------------------
// psum_requant_pack
//
// Purpose: drains N_PEs partial sums from the PE array shift chain, one per
// shift cycle, requantizes each one (arithmetic right shift, then saturation
// to DATA_WIDTH), packs PACK_N results per word (first result in the MSB lane)
// and buffers the words in a small show-ahead FIFO feeding a valid/ready
// stream.
//
// Optional feature: define PSUM_ROUND_EN to add round-half-up (1 << (shamt-1))
// before the shift. Without it the requant is a pure truncating shift.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      synchronous, active-high; clears all state
//   start      one-cycle pulse, starts a drain (accepted only in IDLE)
//   shamt      right-shift amount, sampled at start
//   out_sign   1: signed saturation, 0: unsigned saturation; sampled at start
//   psum_in    signed psum from the array, captured when shift_req=1
//   shift_req  shift strobe to the array (combinational)
//   out_data   FIFO head word (0 while empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head word
//   busy       high from the accepted start until the drain completes
//   done       one-cycle pulse when the last word of a drain is pushed
// -----------------------------------------------------------------------------
module psum_requant_pack #(
  parameter int PSUM_WIDTH  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int N_PEs       = 16,
  parameter int PACK_N      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [SHIFT_WIDTH-1:0]       shamt,
  input  logic                         out_sign,
  input  logic [PSUM_WIDTH-1:0]        psum_in,
  output logic                         shift_req,
  output logic [DATA_WIDTH*PACK_N-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int XW  = PSUM_WIDTH + 1;
  localparam int WW  = DATA_WIDTH * PACK_N;
  localparam int CW  = $clog2(N_PEs + 1);
  localparam int LW  = (PACK_N > 1) ? $clog2(PACK_N) : 1;
  localparam int PTW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  localparam logic signed [XW-1:0] C_SMAX = XW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] C_SMIN = XW'(-(64'sd1 <<< (DATA_WIDTH - 1)));
  localparam logic signed [XW-1:0] C_UMAX = XW'((64'sd1 <<< DATA_WIDTH) - 64'sd1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_remaining;
  logic [SHIFT_WIDTH-1:0]  r_shamt;
  logic                    r_sign;
  logic                    r_q_valid;
  logic [DATA_WIDTH-1:0]   r_q_data;
  logic [LW-1:0]           r_lane;
  logic [WW-1:0]           r_pack;
  logic [WW-1:0]           r_mem [FIFO_DEPTH];
  logic [PTW-1:0]          r_wptr;
  logic [PTW-1:0]          r_rptr;
  logic [FCW-1:0]          r_count;

  logic signed [XW-1:0]    w_x;
  logic signed [XW-1:0]    w_xr;
  logic signed [XW-1:0]    w_y;
  logic [DATA_WIDTH-1:0]   w_q;
  logic [WW-1:0]           w_word;
  logic                    w_push;
  logic                    w_pop;

  // ---------------------------------------------------------------------------
  // Requantization of the psum currently on the chain.
  // ---------------------------------------------------------------------------
  assign w_x = {psum_in[PSUM_WIDTH-1], psum_in};

`ifdef PSUM_ROUND_EN
  // One extra bit of headroom means the rounding bias can never overflow.
  logic signed [XW-1:0] w_bias;
  assign w_bias = (r_shamt == '0) ? '0 : (XW'(1) << (r_shamt - 1'b1));
  assign w_xr   = w_x + w_bias;
`else
  assign w_xr = w_x;
`endif

  assign w_y = w_xr >>> r_shamt;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_q = w_y[DATA_WIDTH-1:0];
    if (r_sign) begin
      if (w_y > C_SMAX)      w_q = C_SMAX[DATA_WIDTH-1:0];
      else if (w_y < C_SMIN) w_q = C_SMIN[DATA_WIDTH-1:0];
    end else begin
      if (w_y[XW-1])         w_q = '0;
      else if (w_y > C_UMAX) w_q = C_UMAX[DATA_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Packer: lane 0 is the MSB lane. A word is pushed when its last lane fills,
  // or in FLUSH when the final (possibly partial) word is complete.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_word = r_pack;
    w_word[(PACK_N - 1 - int'(r_lane)) * DATA_WIDTH +: DATA_WIDTH] = r_q_data;
  end

  assign w_push = r_q_valid && ((r_lane == LW'(PACK_N - 1)) || (r_state == S_FLUSH));
  assign w_pop  = out_valid && out_ready;

  // Holding one slot in reserve leaves room for the single word in flight.
  assign shift_req = (r_state == S_DRAIN) && (r_remaining != '0) &&
                     (r_count < FCW'(FIFO_DEPTH - 1));
  assign done      = (r_state == S_FLUSH) && w_push;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rptr] : '0;

  function automatic logic [PTW-1:0] next_ptr(input logic [PTW-1:0] p);
    return (p == PTW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_shamt     <= '0;
      r_sign      <= 1'b0;
      r_q_valid   <= 1'b0;
      r_q_data    <= '0;
      r_lane      <= '0;
      r_pack      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state     <= S_DRAIN;
          r_remaining <= CW'(N_PEs);
          r_shamt     <= shamt;
          r_sign      <= out_sign;
        end
        S_DRAIN: if (shift_req && (r_remaining == CW'(1))) r_state <= S_FLUSH;
        S_FLUSH: if (w_push) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (shift_req) begin
        r_remaining <= r_remaining - 1'b1;
        r_q_data    <= w_q;
      end
      r_q_valid <= shift_req;

      if (r_q_valid) begin
        if (w_push) begin
          r_pack <= '0;
          r_lane <= '0;
        end else begin
          r_pack <= w_word;
          r_lane <= r_lane + 1'b1;
        end
      end

      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the FIFO storage is not reset; validity is tracked by r_count and
  // out_data is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

endmodule

// File: tb/tb_psum_requant_pack.sv
// -----------------------------------------------------------------------------
// tb_psum_requant_pack
//
// Directed bench for psum_requant_pack with the default parameters. Inputs are
// driven 1 time unit after the rising edge, outputs are sampled on the falling
// edge. Popped words are collected by a monitor and compared against
// hand-computed words. Expectations that depend on rounding follow
// PSUM_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_psum_requant_pack;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  shamt;
  logic        out_sign;
  logic [31:0] psum_in;
  logic        shift_req;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  psum_requant_pack dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shamt     (shamt),
    .out_sign  (out_sign),
    .psum_in   (psum_in),
    .shift_req (shift_req),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Psum source: the array shifts one psum per shift_req cycle.
  logic [31:0] psum_tab [16];
  int          cap_idx;

  always @(posedge clk) begin
    if (reset || (start && !busy)) cap_idx <= 0;
    else if (shift_req)            cap_idx <= cap_idx + 1;
  end

  assign psum_in = psum_tab[cap_idx & 15];

  // Pop monitor.
  logic [31:0] got_q [$];

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(out_data);
  end

  // Drain observations.
  int n_shift, n_done, first_k, last_k, done_k, shift_stall;
  logic busy1, busy_after;

  task automatic run_drain(input logic [4:0] sh, input bit sg, input bit extra, input int ready_at);
    got_q.delete();
    n_shift = 0; n_done = 0; first_k = -1; last_k = -1; done_k = -1;
    shift_stall = -1; busy1 = 1'b0; busy_after = 1'b1;
    @(posedge clk); #1;
    shamt = sh; out_sign = sg; start = 1'b1; out_ready = (ready_at == 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (shift_req) begin
        n_shift++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k == 1) busy1 = busy;
      if (done_k >= 0 && k == done_k + 1) busy_after = busy;
      if (ready_at > 0 && k == ready_at - 1) shift_stall = n_shift;
      if (done_k >= 0 && k >= done_k + 4) break;
      @(posedge clk); #1;
      start     = extra && ((k + 1 == 5) || (k + 1 == 17));
      out_ready = (k + 1 >= ready_at);
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_words(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_w [4];
    exp_w = '{e0, e1, e2, e3};
    check({tag, "_nwords"}, 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_w%0d", tag, i), (i < got_q.size()) ? 64'(got_q[i]) : 64'hx, 64'(exp_w[i]));
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) psum_tab[i] = 32'(i);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; shamt = '0; out_sign = 1'b0; out_ready = 1'b1;
    load_ramp();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_shift_req", 64'(shift_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);

    // Ramp 0..15, shamt 0, signed, consumer always ready.
    run_drain(5'd0, 1'b1, 1'b0, 0);
    check_words("ramp", 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);
    check("ramp_n_shift",    64'(n_shift),    64'd16);
    check("ramp_first_k",    64'(first_k),    64'd1);
    check("ramp_last_k",     64'(last_k),     64'd16);
    check("ramp_done_k",     64'(done_k),     64'd17);
    check("ramp_n_done",     64'(n_done),     64'd1);
    check("ramp_busy1",      64'(busy1),      64'd1);
    check("ramp_busy_after", 64'(busy_after), 64'd0);

    // Shift by 4, with and without rounding.
    psum_tab = '{32'h00000128, 32'hFFFFFED8, 32'h7FFFFFFF, 32'h00000018,
                 32'hFFFFFFF8, 32'h00000007, 32'h00000008, 32'hFFFFFFF7,
                 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_drain(5'd4, 1'b1, 1'b0, 0);
`ifdef PSUM_ROUND_EN
    check_words("shift4", 32'h13EE7F02, 32'h000001FF, 32'h0, 32'h0);
`else
    check_words("shift4", 32'h12ED7F01, 32'hFF0000FF, 32'h0, 32'h0);
`endif

    // Signed saturation, shamt 0 (rounding has no effect).
    psum_tab = '{32'h00010000, 32'hFFFFFED4, 32'hFFFFFFFF, 32'h00000128,
                 32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFFFF7F,
                 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_drain(5'd0, 1'b1, 1'b0, 0);
    check_words("sat_s", 32'h7F80FF7F, 32'h7F807F80, 32'h0, 32'h0);

    // Unsigned saturation.
    psum_tab = '{32'hFFFFFFFB, 32'h0000012C, 32'h000000C8, 32'h000000FF,
                 32'h00000100, 32'h00000000, 32'h00000001, 32'hFFFFFFFF,
                 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_drain(5'd0, 1'b0, 1'b0, 0);
    check_words("sat_u", 32'h00FFC8FF, 32'hFF000100, 32'h0, 32'h0);

    // Back-pressure: consumer stalled until cycle 40.
    load_ramp();
    run_drain(5'd0, 1'b1, 1'b0, 40);
    check("stall_shift_before", 64'(shift_stall), 64'd13);
    check("stall_n_shift",      64'(n_shift),     64'd16);
    check("stall_done_k",       64'(done_k),      64'd44);
    check("stall_n_done",       64'(n_done),      64'd1);
    check_words("stall", 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);

    // start while busy and start coincident with done are ignored.
    run_drain(5'd0, 1'b1, 1'b1, 0);
    check("extra_n_shift",    64'(n_shift),    64'd16);
    check("extra_last_k",     64'(last_k),     64'd16);
    check("extra_done_k",     64'(done_k),     64'd17);
    check("extra_n_done",     64'(n_done),     64'd1);
    check("extra_busy_after", 64'(busy_after), 64'd0);
    check_words("extra", 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);

    // Reset after 6 captures (cycles 1..6), consumer stalled.
    got_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_shift_req", 64'(shift_req), 64'd1);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_shift_req", 64'(shift_req), 64'd0);
    check("mid_rst_popped",    64'(got_q.size()), 64'd0);
    out_ready = 1'b1;
    run_drain(5'd0, 1'b1, 1'b0, 0);
    check("post_rst_n_shift", 64'(n_shift), 64'd16);
    check("post_rst_done_k",  64'(done_k),  64'd17);
    check_words("post_rst", 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_requant_pack.md
Name: psum_requant_pack

Overview:
- Downstream stage of the PE array.
- After accumulation, it drains the N_PEs partial sums from the array's shift chain, one per shift cycle.
- Each psum is requantized (arithmetic right shift, then saturation to DATA_WIDTH). PACK_N results are packed into one word and buffered in a small show-ahead FIFO.
- Output is a valid/ready stream towards the output-activation writeback.

Parameters:
- PSUM_WIDTH, 32, width of the psum from the array.
- DATA_WIDTH, 8, width of the requantized activation.
- N_PEs, 16, psums drained per start.
- PACK_N, 4, activations per output word.
- FIFO_DEPTH, 4, output FIFO entries; must be >= 2.
- SHIFT_WIDTH, 5, width of shamt.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a drain of N_PEs psums. Ignored while busy.
- shamt  in  SHIFT_WIDTH  right-shift amount. Sampled at start and held internally for the drain.
- out_sign  in  1  sampled at start. 1: signed saturation [-2^(D-1), 2^(D-1)-1]. 0: unsigned [0, 2^D-1].
- psum_in  in  PSUM_WIDTH  array psum_out, signed; valid in any cycle where shift_req=1.
- shift_req  out  1  drives the array's shift; psum_in is captured in the same cycle.
- out_data  out  DATA_WIDTH*PACK_N  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts; pop when out_valid & out_ready.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the last word of a drain is pushed to the FIFO.

Behaviour:
- Reset values:
  - shift_req, out_valid, busy and done are 0.
  - out_data is 0.
  - FIFO is empty, all counters are 0, FSM is in IDLE.
- FSM states and transitions:
  - IDLE -> DRAIN on start.
  - DRAIN -> FLUSH when all N_PEs psums are captured.
  - FLUSH -> IDLE when the last word is pushed; done pulses in that cycle.
- shift_req is combinational: (state==DRAIN) && remaining!=0 && fifo_count < FIFO_DEPTH-1.
  - At most one word is ever in flight, so the FIFO never overflows.
  - psum_in is never captured without shift_req.
- Requant stage (1-cycle register):
  - x = sign-extend(psum_in) to PSUM_WIDTH+1 bits.
  - y = x >>> shamt.
  - Clamp y to the out_sign range and truncate to DATA_WIDTH.
  - No wrap-around is permitted.
- Packer:
  - The first result of a word occupies the MSB lane [DATA_WIDTH*PACK_N-1 -: DATA_WIDTH]; later results fill towards the LSB.
  - The word is pushed after PACK_N results.
- If N_PEs is not a multiple of PACK_N, FLUSH pushes the final partial word with the unfilled low lanes zero. Words per drain = ceil(N_PEs/PACK_N).
- Latency: capture cycle C, requant register C+1, push at the end of C+1. out_valid rises in cycle C+2 for the final lane of a word.
- FIFO push and pop may occur in the same cycle: fifo_count is unchanged and order is preserved.
- start asserted in the same cycle as done is ignored. A new start is accepted only in IDLE.
- FIFO contents of a previous drain persist across drains until popped; done does not wait for FIFO empty.
- Reset mid-operation:
  - At the next edge the FSM returns to IDLE and the FIFO and packer are cleared.
  - shift_req is 0 from the following cycle; partial words are discarded.

Optional Feature:
- Macro: PSUM_ROUND_EN.
- When defined:
  - The requant stage adds 1<<(shamt-1) to x before shifting, when shamt != 0 (round-half-up).
  - The addition is done at PSUM_WIDTH+1 bits, so it cannot overflow.
- When undefined: pure truncating arithmetic shift, with no adder in the path.

Test Plan:
- shamt=0, out_sign=1, psums 0..15, out_ready=1 -> 4 words: 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F. shift_req is high for 16 consecutive cycles, then done pulses once.
- shamt=4, psum 0x00000128 in lane 0 -> byte 0x12 without PSUM_ROUND_EN, 0x13 with it. shamt=0 with PSUM_ROUND_EN -> no change (0x128 saturates to 0x7F signed).
- Saturation:
  - Signed: 0x00010000 -> 0x7F, -300 -> 0x80, -1 -> 0xFF.
  - Unsigned: -5 -> 0x00, 300 -> 0xFF, 200 -> 0xC8.
- out_ready=0 during a 16-psum drain, FIFO_DEPTH=4:
  - fifo_count never exceeds 4; shift_req deasserts once fifo_count reaches 3.
  - Raising out_ready yields all 4 words in order with no loss or duplication, and exactly 16 shift_req cycles in total.
- start during busy and start coincident with done -> ignored: no extra shift_req, and busy/done timing is unchanged.
- reset asserted after 6 psums captured -> next cycle out_valid=0, busy=0, shift_req=0. A following start drains 16 psums normally.
